// File: rtl/fifo_arb_pkg.sv
// Shared types and occupancy helper for the FIFO write-port arbiter.
// Sized for the default 6-bit FIFO pointers (32-entry FIFO with a wrap bit).
package fifo_arb_pkg;

   localparam int unsigned OCC_PTR_W = 6;
   localparam int unsigned DEPTH     = 2 ** (OCC_PTR_W - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Pointer difference wraps on the full pointer width.
   // The in-flight write is the one not yet visible in wrptr.
   function automatic logic [OCC_PTR_W-1:0] occ_f(
      input logic [OCC_PTR_W-1:0] wrptr,
      input logic [OCC_PTR_W-1:0] rdptr,
      input logic                 inflight
   );
      return wrptr - rdptr + {{(OCC_PTR_W-1){1'b0}}, inflight};
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping modulo N; returns a one-hot grant and the winning index.
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   always_comb begin : pick
      int unsigned j;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(ptr_i) + k;
         if (j >= N) j = j - N;
         if (!valid_o && req_i[IW'(j)]) begin
            valid_o            = 1'b1;
            gnt_o[IW'(j)]      = 1'b1;
            idx_o              = IW'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers,
// with packet lock and overflow protection that counts the in-flight write.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned FIFO_WIDTH = 8,
   parameter int unsigned PTR_W      = OCC_PTR_W,
   parameter int unsigned AF_THRESH  = 28
) (
   input  logic                            clk,
   input  logic                            rstN,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              req_last,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              gnt,
   input  logic                            fifo_full,
   input  logic [PTR_W-1:0]                fifo_wrptr,
   input  logic [PTR_W-1:0]                fifo_rdptr,
   output logic                            wr_en,
   output logic [FIFO_WIDTH-1:0]           data_in,
   output logic [$clog2(NUM_REQ)-1:0]      owner,
   output logic                            locked,
   output logic [PTR_W-1:0]                occupancy,
   output logic                            almost_full
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_e              state_q, state_d;
   logic [IDX_W-1:0]        rr_q, rr_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic                    wr_en_q, wr_en_d;
   logic [FIFO_WIDTH-1:0]   data_q, data_d;
   logic                    af_q, af_d;

   logic [NUM_REQ-1:0]      pick_gnt;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_vld;
   logic                    can_wr;
   logic                    acc_last;
   logic [IDX_W-1:0]        acc_idx;

   assign occupancy = occ_f(fifo_wrptr, fifo_rdptr, wr_en_q);
   assign can_wr    = !fifo_full && (occupancy < PTR_W'(DEPTH));

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IDX_W)
   ) u_pick (
      .req_i   (req),
      .ptr_i   (rr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_vld)
   );

   // Grant selection, FSM next state and registered write-side payload.
   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      owner_d  = owner_q;
      wr_en_d  = 1'b0;
      data_d   = data_q;
      af_d     = (occupancy >= PTR_W'(AF_THRESH));
      gnt      = '0;
      acc_idx  = owner_q;
      acc_last = 1'b0;

      if (!rstN && can_wr) begin
         if (state_q == IDLE) begin
            if (pick_vld) begin
               gnt     = pick_gnt;
               acc_idx = pick_idx;
            end
         end else begin
            gnt[owner_q] = req[owner_q];
         end
      end

      if (|(gnt & req)) begin
         wr_en_d  = 1'b1;
         owner_d  = acc_idx;
         acc_last = |(gnt & req_last);
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) data_d = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
         end
         if (state_q == IDLE) begin
            rr_d = (acc_idx == IDX_W'(NUM_REQ - 1)) ? '0 : acc_idx + IDX_W'(1);
            if (!acc_last) state_d = LOCKED;
         end else if (acc_last) begin
            state_d = IDLE;
         end
      end
   end

   // Reset abandons any packet in progress without waiting for its last beat.
   always_ff @(posedge clk) begin
      if (rstN) begin
         state_q <= IDLE;
         rr_q    <= '0;
         owner_q <= '0;
         wr_en_q <= 1'b0;
         data_q  <= '0;
         af_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         wr_en_q <= wr_en_d;
         data_q  <= data_d;
         af_q    <= af_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign data_in     = data_q;
   assign owner       = owner_q;
   assign locked      = (state_q == LOCKED);
   assign almost_full = af_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed plan steps followed by
// randomized producers and FIFO reads, checked against a behavioural model.
module tb_fifo_wr_arb;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int PW = 6;

   logic             clk = 1'b0;
   logic             rstN;
   logic [N-1:0]     req, req_last, gnt;
   logic [N*W-1:0]   req_data;
   logic             fifo_full;
   logic [PW-1:0]    wrptr, rdptr;
   logic             wr_en;
   logic [W-1:0]     data_in;
   logic [1:0]       owner;
   logic             locked;
   logic [PW-1:0]    occupancy;
   logic             almost_full;

   always #5 clk = ~clk;

   fifo_wr_arb #(.NUM_REQ(N), .FIFO_WIDTH(W), .PTR_W(PW), .AF_THRESH(28)) dut (
      .clk(clk), .rstN(rstN), .req(req), .req_last(req_last), .req_data(req_data),
      .gnt(gnt), .fifo_full(fifo_full), .fifo_wrptr(wrptr), .fifo_rdptr(rdptr),
      .wr_en(wr_en), .data_in(data_in), .owner(owner), .locked(locked),
      .occupancy(occupancy), .almost_full(almost_full)
   );

   // Reference model state
   bit         m_locked, m_wr_en, m_af;
   int         m_owner, m_rr;
   logic [7:0] m_data;

   int         npass, nchk, nfail;
   bit         auto_fifo;
   int         rd_pct;
   int         prod_left[N];
   logic [N-1:0] acc_prev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_wr_en = 0; m_af = 0; m_owner = 0; m_rr = 0; m_data = 8'h00;
   endtask

   // One clock: check combinational outputs, advance model and FIFO, check registers.
   task automatic step();
      int occ, j;
      bit can, cur_wr, rd;
      logic [N-1:0] eg;
      #1;
      occ = int'(6'(wrptr - rdptr)) + (m_wr_en ? 1 : 0);
      can = !fifo_full && occ < 32;
      eg  = '0;
      if (!rstN && can) begin
         if (m_locked) begin
            if (req[m_owner]) eg[m_owner] = 1'b1;
         end else begin
            for (int k = 0; k < N; k++) begin
               j = (m_rr + k) % N;
               if (req[j] && eg == '0) eg[j] = 1'b1;
            end
         end
      end
      chk("gnt", 32'(gnt), 32'(eg));
      chk("occupancy", 32'(occupancy), 32'(occ % 64));
      cur_wr   = wr_en;
      acc_prev = req & gnt;
      rd = auto_fifo && (6'(wrptr - rdptr) != 6'd0) && ($urandom_range(0, 99) < rd_pct);
      @(posedge clk);
      #1;
      if (rstN) model_reset();
      else begin
         m_af    = (occ >= 28);
         m_wr_en = 0;
         for (int k = 0; k < N; k++) begin
            if (eg[k]) begin
               m_wr_en = 1;
               m_data  = req_data[k*W +: W];
               m_owner = k;
               if (!m_locked) m_rr = (k + 1) % N;
               m_locked = !req_last[k];
            end
         end
      end
      if (auto_fifo) begin
         if (cur_wr) wrptr = wrptr + 6'd1;
         if (rd)     rdptr = rdptr + 6'd1;
         chk("no_overflow", 32'(6'(wrptr - rdptr) <= 6'd32), 32'd1);
         fifo_full = (6'(wrptr - rdptr) == 6'd32);
      end
      chk("wr_en", 32'(wr_en), 32'(m_wr_en));
      chk("data_in", 32'(data_in), 32'(m_data));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("almost_full", 32'(almost_full), 32'(m_af));
   endtask

   task automatic do_reset();
      rstN = 1'b1;
      step();
      rstN = 1'b0;
   endtask

   initial begin
      logic [N-1:0] exp_seq[6];
      bit           exp_lock[6];
      npass = 0; nchk = 0; nfail = 0;
      rstN = 1'b1; req = '0; req_last = '0; req_data = '0;
      fifo_full = 1'b0; wrptr = '0; rdptr = '0; auto_fifo = 0; rd_pct = 0;
      foreach (prod_left[i]) prod_left[i] = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_wr_en", 32'(wr_en), 32'd0);
      chk("reset_locked", 32'(locked), 32'd0);
      do_reset();

      // Plan 1: round-robin order with single-beat packets
      auto_fifo = 1;
      req = 4'hF; req_last = 4'hF;
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int c = 0; c < 5; c++) begin
         logic [7:0] v;
         #1 chk("t1_order", 32'(gnt), 32'(1 << (c % 4)));
         step();
         v = 8'(8'h11 * ((c % 4) + 1));
         chk("t1_wr_en", 32'(wr_en), 32'd1);
         chk("t1_data", 32'(data_in), 32'(v));
      end

      // Plan 2: 3-beat packet from producer 2 is not interleaved
      rd_pct = 100;
      do_reset();
      req = 4'hF; req_last = 4'b1011;
      exp_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
      exp_lock = '{0, 0, 1, 1, 0, 0};
      for (int c = 0; c < 6; c++) begin
         #1 chk("t2_gnt", 32'(gnt), 32'(exp_seq[c]));
         step();
         chk("t2_locked", 32'(locked), 32'(exp_lock[c]));
         if (c == 3) req_last = 4'hF;
      end

      // Plan 3: 31 entries, in-flight write blocks the second grant
      req = '0; rd_pct = 0;
      do_reset();
      step();
      wrptr = 6'd31; rdptr = 6'd0; fifo_full = 1'b0;
      req = 4'b0001; req_last = 4'b0001; req_data[7:0] = 8'hA5;
      #1 chk("t3_first", 32'(gnt), 32'd1);
      step();
      #1 chk("t3_inflight_block", 32'(gnt), 32'd0);
      step();
      #1 chk("t3_full_block", 32'(gnt), 32'd0);
      step();
      rdptr = rdptr + 6'd1; fifo_full = 1'b0;
      #1 chk("t3_after_read", 32'(gnt), 32'd1);
      step();
      req = '0;
      step();

      // Plan 4: pointer wrap and almost_full threshold
      auto_fifo = 0; fifo_full = 1'b0;
      wrptr = 6'h02; rdptr = 6'h3F;
      #1 chk("t4_wrap_occ", 32'(occupancy), 32'd3);
      step();
      chk("t4_af_low", 32'(almost_full), 32'd0);
      wrptr = 6'h1C; rdptr = 6'h00;
      #1 chk("t4_af_not_yet", 32'(almost_full), 32'd0);
      step();
      chk("t4_af_high", 32'(almost_full), 32'd1);

      // Plan 5: fifo_full overrides pointer arithmetic
      fifo_full = 1'b1; wrptr = 6'd10; rdptr = 6'd0; req = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         #1 chk("t5_gnt", 32'(gnt), 32'd0);
         step();
         chk("t5_wr_en", 32'(wr_en), 32'd0);
      end
      req = '0; fifo_full = 1'b0;
      step();

      // Plan 6: reset mid-packet abandons the lock
      wrptr = '0; rdptr = '0; auto_fifo = 1; rd_pct = 100;
      do_reset();
      req = 4'b0010; req_last = 4'b0000; req_data[15:8] = 8'h5C;
      step();
      chk("t6_locked", 32'(locked), 32'd1);
      rstN = 1'b1;
      step();
      chk("t6_unlock", 32'(locked), 32'd0);
      chk("t6_wr_en", 32'(wr_en), 32'd0);
      rstN = 1'b0;
      req = 4'b0011; req_last = 4'b0011;
      #1 chk("t6_p0_wins", 32'(gnt), 32'd1);
      step();

      // Randomized producers, variable drain rate, occasional reset
      req = '0; req_last = '0;
      for (int c = 0; c < 3000; c++) begin
         rd_pct = ((c / 500) % 2 == 1) ? 30 : 90;
         rstN   = ($urandom_range(0, 299) == 0);
         step();
         for (int i = 0; i < N; i++) begin
            if (acc_prev[i]) begin
               prod_left[i]--;
               req_data[i*W +: W] = 8'($urandom);
               if (prod_left[i] <= 0) req[i] = 1'b0;
            end
            if (!req[i] && $urandom_range(0, 2) == 0) begin
               prod_left[i] = $urandom_range(1, 4);
               req[i] = 1'b1;
               req_data[i*W +: W] = 8'($urandom);
            end
            req_last[i] = (prod_left[i] == 1);
         end
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin write-port arbiter that shares the single write port of the 8-bit FIFO among NUM_REQ producers.
- Supports packet lock: a multi-beat packet from one producer is never interleaved with beats from another producer.
- Guarantees no write is issued to a full FIFO, using the FIFO's wrptr/rdptr to compute occupancy, including a write already in flight.
- Sits between the producer agents/blocks and the FIFO write side (wr_en, data_in).

Parameters:
- NUM_REQ, 4: number of producers (2..8).
- FIFO_WIDTH, 8: data width.
- PTR_W, 6: FIFO pointer width. FIFO depth is DEPTH = 2**(PTR_W-1) = 32; the MSB is the wrap bit.
- AF_THRESH, 28: almost_full asserts when effective occupancy >= AF_THRESH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstN  in  1  synchronous, active-high reset (1 = reset), despite the suffix.
- req  in  NUM_REQ  per-producer write request; held until granted.
- req_last  in  NUM_REQ  marks the final beat of a packet; qualified by req.
- req_data  in  NUM_REQ*FIFO_WIDTH  producer data; slice i belongs to producer i.
- gnt  out  NUM_REQ  one-hot grant, combinational; beat accepted when req[i]&gnt[i].
- fifo_full  in  1  FIFO full flag.
- fifo_wrptr  in  PTR_W  FIFO write pointer.
- fifo_rdptr  in  PTR_W  FIFO read pointer.
- wr_en  out  1  registered FIFO write enable.
- data_in  out  FIFO_WIDTH  registered FIFO write data.
- owner  out  $clog2(NUM_REQ)  index of the last granted producer (registered).
- locked  out  1  high while a packet is in progress.
- occupancy  out  PTR_W  effective occupancy (combinational).
- almost_full  out  1  registered; set when occupancy >= AF_THRESH.

Behaviour:
- Reset (rstN=1 at an edge):
  - wr_en=0, data_in=0, owner=0, locked=0, almost_full=0.
  - Round-robin pointer rr_ptr=0; FSM goes to IDLE.
  - gnt is 0 during any cycle in which rstN=1.
- Occupancy and write permission:
  - occupancy = (fifo_wrptr - fifo_rdptr) mod 2**PTR_W, plus wr_en (the in-flight write not yet reflected in wrptr).
  - can_wr = !fifo_full && (occupancy < DEPTH).
  - gnt is all-zero whenever can_wr=0.
- FSM IDLE:
  - If can_wr and any req is high: grant the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - On grant: owner <= i, rr_ptr <= (i+1) mod NUM_REQ.
  - If req_last[i]=0, go to LOCKED; otherwise stay in IDLE.
- FSM LOCKED:
  - Only req[owner] may be granted, and only when can_wr. All other requesters see gnt=0.
  - When a granted beat has req_last[owner]=1, return to IDLE. rr_ptr is not changed in LOCKED.
- Write latency: a beat accepted in cycle t gives wr_en=1 and data_in=req_data[i] in cycle t+1, exactly 1 cycle later.
  - wr_en=0 in any cycle following a cycle with no accepted beat.
  - data_in holds its previous value when wr_en=0.
- Throughput: 1 beat/cycle while the FIFO is not near full. Back-to-back grants are allowed because occupancy counts the in-flight write.
- Boundaries:
  - Occupancy 31 with wr_en=1 gives effective 32, so no grant; this prevents overflow.
  - Pointer wrap (wrptr=0x02, rdptr=0x3F) gives occupancy 3; the modular subtraction is mandatory.
  - fifo_full=1 forces gnt=0 even if the pointer arithmetic disagrees.
  - A single-beat packet (req_last=1 on the first beat) never enters LOCKED.
  - Reset mid-packet abandons the lock. Reset does not wait for req_last.
- locked equals (state==LOCKED).
- almost_full <= (occupancy >= AF_THRESH) on every clock edge.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum arb_state_e {IDLE, LOCKED};
  - localparam DEPTH;
  - function occ_f(wrptr, rdptr, inflight).
- One sub-module, rr_pick: combinational round-robin picker taking a request vector and rr_ptr, and returning a one-hot grant and its index. It is reused by any future read-side scheduler.

Test Plan:
1. Reset, then req=4'b1111 with all req_last=1 and an empty FIFO -> gnt order is 0,1,2,3,0 on successive cycles; wr_en is high from cycle 2 onward; data_in follows each granted producer's data with 1-cycle lag.
2. Producer 2 sends a 3-beat packet (last on beat 3) while req=4'b1111 -> gnt=4'b0100 for 3 consecutive cycles, locked=1 for 2 cycles, then producer 3 is granted next.
3. Preload the FIFO to 31 entries, then req[0]=1 held -> exactly one grant; the next cycle gnt=0 (effective occupancy 32); after one FIFO read, one more grant.
4. Set wrptr=6'h02, rdptr=6'h3F -> occupancy=3 and almost_full=0. Set wrptr=6'h1C, rdptr=6'h00 -> almost_full=1 one cycle later.
5. Force fifo_full=1 with pointers indicating 10 entries and req=4'b0001 -> gnt stays 0 and wr_en stays 0 while full is high.
6. Assert rstN during beat 2 of a LOCKED packet from producer 1 -> the next cycle has locked=0, wr_en=0, rr_ptr=0; after release, producer 0 wins if requesting.
